// File: rtl/chaotic_pkg.sv
// Shared constants and types for the chaotic z-channel bit extraction path.
// FP64 field positions, serializer state encoding and a finite-normal test.
package chaotic_pkg;

    localparam int          FP64_EXP_MSB  = 62;
    localparam int          FP64_EXP_LSB  = 52;
    localparam int          FP64_MANT_W   = 52;
    localparam logic [10:0] FP64_EXP_ALL1 = 11'h7FF;

    typedef enum logic {
        IDLE,
        SHIFT
    } ser_state_t;

    // Exponent all-ones (Inf/NaN) and all-zeros (zero/subnormal) are both rejected.
    function automatic logic fp64_exp_ok(input logic [10:0] exp_f);
        return (exp_f != FP64_EXP_ALL1) && (exp_f != '0);
    endfunction

endpackage

// File: rtl/chaotic_z_bit_extractor_if.sv
// Sample-in / bit-stream-out bus of the z-bit extractor.
// The master drives samples and bit_ready; the slave (extractor) drives the bit stream.
interface chaotic_z_bit_extractor_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  en;
    logic                  zn1_valid;
    logic [DATA_WIDTH-1:0] zn1;
    logic                  bit_ready;
    logic                  bit_valid;
    logic                  bit_out;

    modport master (
        output en, zn1_valid, zn1, bit_ready,
        input  bit_valid, bit_out
    );

    modport slave (
        input  en, zn1_valid, zn1, bit_ready,
        output bit_valid, bit_out
    );
endinterface

// File: rtl/chaotic_sync_fifo.sv
// Single-clock FIFO with registered occupancy; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module chaotic_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic             w_pop;
    logic             w_push;

    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// File: rtl/chaotic_z_bit_extractor.sv
// Extracts a mantissa bit window from each valid float64 zn1, buffers the
// samples and serializes them MSB-first onto a valid/ready bit stream.
module chaotic_z_bit_extractor
    import chaotic_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int BITS_PER_SAMPLE = 8,
    parameter int BIT_OFFSET      = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    chaotic_z_bit_extractor_if.slave      zbus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   drop_cnt,
    output logic                          fp_err
);
    localparam int CNT_W = (BITS_PER_SAMPLE > 1) ? $clog2(BITS_PER_SAMPLE) : 1;

    logic [DATA_WIDTH-1:0]      w_zn1;
    logic [10:0]                w_exp;
    logic                       w_capture;
    logic                       w_exp_ok;
    logic                       w_push_req;
    logic [BITS_PER_SAMPLE-1:0] w_chunk;
    logic [BITS_PER_SAMPLE-1:0] w_fifo_rdata;
    logic                       w_fifo_full;
    logic                       w_fifo_empty;
    logic                       w_pop;
    logic                       w_last_hs;
    logic                       w_drop;

    ser_state_t                 r_state;
    ser_state_t                 w_next;
    logic [BITS_PER_SAMPLE-1:0] r_shreg;
    logic [CNT_W-1:0]           r_bit_cnt;

    assign w_zn1      = zbus.zn1;
    assign w_exp      = w_zn1[FP64_EXP_MSB:FP64_EXP_LSB];
    assign w_exp_ok   = fp64_exp_ok(w_exp);
    assign w_capture  = zbus.zn1_valid && zbus.en;
    assign w_push_req = w_capture && w_exp_ok;
    assign w_chunk    = w_zn1[BIT_OFFSET +: BITS_PER_SAMPLE];

    // Last-bit handshake reloads from the FIFO in the same cycle, so samples stay gapless.
    assign w_last_hs = (r_state == SHIFT) && zbus.bit_ready && (r_bit_cnt == '0);
    assign w_pop     = !w_fifo_empty && ((r_state == IDLE) || w_last_hs);
    assign w_drop    = w_push_req && w_fifo_full && !w_pop;

    chaotic_sync_fifo #(
        .WIDTH (BITS_PER_SAMPLE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push_req),
        .i_wdata (w_chunk),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!w_fifo_empty) w_next = SHIFT;
            SHIFT:   if (w_last_hs && w_fifo_empty) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        zbus.bit_valid = (r_state == SHIFT);
        zbus.bit_out   = (r_state == SHIFT) && r_shreg[BITS_PER_SAMPLE-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (w_pop) begin
            r_shreg   <= w_fifo_rdata;
            r_bit_cnt <= CNT_W'(BITS_PER_SAMPLE - 1);
        end else if ((r_state == SHIFT) && zbus.bit_ready) begin
            r_shreg   <= r_shreg << 1;
            r_bit_cnt <= r_bit_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt <= '0;
            fp_err   <= 1'b0;
        end else begin
            if (w_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
            if (w_capture && !w_exp_ok)     fp_err   <= 1'b1;
        end
    end
endmodule

// File: doc/chaotic_z_bit_extractor.md
# chaotic_z_bit_extractor

Downstream consumer of the z-channel forward-Euler stage. Takes each aligned float64 `zn1` result, rejects non-finite or zero/subnormal values, and extracts a fixed window of mantissa bits as one sample. Samples are buffered in a small FIFO and serialized MSB-first onto a valid/ready bit stream that feeds the sequence output logic.

## Interface
- `DATA_WIDTH`, 64: float64 word width; must equal the Floating-point IP width.
- `BITS_PER_SAMPLE`, 8: mantissa bits extracted per sample, 1..32.
- `BIT_OFFSET`, 16: LSB position of the extraction window inside `zn1`; `BIT_OFFSET + BITS_PER_SAMPLE <= 52`.
- `FIFO_DEPTH`, 4: sample FIFO depth, power of two, ≥2.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `en` in 1: capture enable; when low, `zn1_valid` is ignored.
- `zn1_valid` in 1: single-cycle qualifier for `zn1`.
- `zn1` in `DATA_WIDTH`: IEEE-754 double from the z equation stage.
- `bit_ready` in 1: downstream accepts `bit_out`.
- `bit_valid` out 1: `bit_out` is valid.
- `bit_out` out 1: serialized bit, MSB of each sample first.
- `fifo_level` out `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.
- `drop_cnt` out 16: samples lost to a full FIFO, saturating at 16'hFFFF.
- `fp_err` out 1: sticky; set when a non-finite, zero or subnormal sample is rejected.

## Operation
- Capture occurs when `zn1_valid && en`. Let `exp = zn1[62:52]`.
  - If `exp == 11'h7FF` or `exp == 0`: reject, set `fp_err`, do not push, do not count as a drop.
  - Otherwise `chunk = zn1[BIT_OFFSET +: BITS_PER_SAMPLE]` and push it.
- The push is accepted when the FIFO is not full or a pop occurs in the same cycle. Otherwise the sample is dropped and `drop_cnt` increments, holding at 16'hFFFF.
- Serializer FSM:
  - IDLE: `bit_valid=0`. If the FIFO is non-empty, pop into the shift register, set `bit_cnt=BITS_PER_SAMPLE-1`, go to SHIFT.
  - SHIFT: `bit_valid=1`, `bit_out=shreg[MSB]`. On `bit_valid && bit_ready`, shift left and decrement `bit_cnt`.
  - Handshake on the last bit (`bit_cnt==0`): if the FIFO is non-empty, pop and reload in the same cycle and stay in SHIFT with no bubble. Otherwise go to IDLE.
- `bit_out` and `bit_valid` are held stable while `bit_valid && !bit_ready`.
- `en` low does not stall the serializer; buffered samples still drain.
- `fp_err` clears only on reset.

## Timing
- Reset values: `bit_valid=0`, `bit_out=0`, `fifo_level=0`, `drop_cnt=0`, `fp_err=0`, FSM=IDLE, FIFO pointers=0.
- Reset asserted mid-stream discards the FIFO and shift register immediately at the next edge. No partial sample is emitted after release.
- Latency, FIFO empty and FSM IDLE: `zn1_valid` in cycle c gives the push at edge c. The pop happens at edge c+1, so `bit_valid` is high in cycle c+2 with the first bit.
- Throughput is one bit per cycle with `bit_ready=1`. Consecutive samples are gapless.
- `fifo_level` and `drop_cnt` are registered and update one edge after the event.

## Structure
- Shared package `chaotic_pkg`:
  - FP64 field constants `FP64_EXP_MSB=62`, `FP64_EXP_LSB=52`, `FP64_MANT_W=52`, `FP64_EXP_ALL1=11'h7FF`.
  - Serializer state enum `{IDLE, SHIFT}`.
- Sub-module `chaotic_sync_fifo`: width `BITS_PER_SAMPLE`, depth `FIFO_DEPTH`, synchronous active-low reset, full/empty/level outputs, simultaneous push+pop when full permitted.
- The top level contains the field check, extraction, drop counter and serializer FSM.

## Test plan
- **Basic:** `zn1=64'h3FF0_0000_00AB_0000`, `bit_ready=1` → `bit_valid` rises 2 cycles after input. Bits are 1,0,1,0,1,0,1,1 on consecutive cycles, then `bit_valid=0`.
- **Rejection:** `zn1=64'h7FF8_0000_0000_0000`, then `64'h0` → no `bit_valid`, `fp_err=1`, `drop_cnt=0`.
- **Overflow:** `bit_ready=0`, 6 back-to-back valid samples → the serializer holds sample 1, the FIFO holds samples 2–5, `fifo_level=4`, `drop_cnt=1`. Releasing `bit_ready` emits 40 bits in order.
- **Backpressure:** toggle `bit_ready` every cycle during a sample → `bit_out` is stable while not ready, and the byte is reconstructed correctly.
- **Enable and reset:** a sample with `en=0` is ignored. Asserting `rst_n=0` mid-sample clears all outputs next edge; a fresh sample after release serializes correctly.
